// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, edge/bit counting, datapath strobes,
// per-frame error collection and the good-frame data_valid pulse.
module uart_rx_ctrl #(
    parameter int unsigned PRESC_W   = 6,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               par_err,
    input  logic               strt_glitch,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               deser_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               parity_error,
    output logic               frame_error
);

    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               par_en_q, par_en_d;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               valid_q, valid_d;

    logic [PRESC_W-1:0] chk_c;
    logic [PRESC_W-1:0] last_c;
    logic               at_chk_c;
    logic               at_last_c;
    logic               ferr_now_c;

    // Check edge sits just after the mid-bit majority window; last edge ends the bit.
    always_comb begin
        chk_c     = PRESC_W'((presc_q >> 1) + PRESC_W'(2));
        last_c    = PRESC_W'(presc_q - PRESC_W'(1));
        at_chk_c  = (edge_q == chk_c);
        at_last_c = (edge_q == last_c);
    end

    // State register and per-frame context.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            presc_q  <= '0;
            par_en_q <= 1'b0;
            edge_q   <= '0;
            bit_q    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            par_en_q <= par_en_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state, counters, strobes and error collection.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        par_en_d    = par_en_q;
        edge_d      = at_last_c ? '0 : PRESC_W'(edge_q + PRESC_W'(1));
        bit_d       = bit_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        valid_d     = 1'b0;
        ferr_now_c  = ferr_q;
        dat_samp_en = (state_q != S_IDLE);
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                edge_d = '0;
                bit_d  = '0;
                if (!RX_IN) begin
                    state_d  = S_START;
                    presc_d  = Prescale;
                    par_en_d = PAR_EN;
                    perr_d   = 1'b0;
                    ferr_d   = 1'b0;
                end
            end

            S_START: begin
                strt_chk_en = at_chk_c;
                if (at_chk_c && strt_glitch) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (at_last_c) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end

            S_DATA: begin
                deser_en = at_chk_c;
                if (at_last_c) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = BIT_W'(bit_q + BIT_W'(1));
                    end
                end
            end

            S_PARITY: begin
                par_chk_en = at_chk_c;
                if (at_chk_c && par_err) begin
                    perr_d = 1'b1;
                end
                if (at_last_c) begin
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                stp_chk_en = at_chk_c;
                if (at_chk_c) begin
                    // Leave the stop bit early so a back-to-back start edge is seen.
                    ferr_now_c = ferr_q | stp_err;
                    ferr_d     = ferr_now_c;
                    valid_d    = !perr_q && !ferr_now_c;
                    state_d    = S_IDLE;
                    edge_d     = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Registered outputs.
    always_comb begin
        edge_cnt     = edge_q;
        bit_cnt      = bit_q;
        data_valid   = valid_q;
        parity_error = perr_q;
        frame_error  = ferr_q;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: serial line driver, checker responders and
// a small deserializer model observing the strobes.
module tb_uart_rx_ctrl;

    localparam int unsigned PW = 6;

    logic          CLK;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic [PW-1:0] Prescale;
    logic          par_err;
    logic          strt_glitch;
    logic          stp_err;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en;
    logic          strt_chk_en;
    logic          deser_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          data_valid;
    logic          parity_error;
    logic          frame_error;

    logic par_inj;
    logic glitch_inj;
    logic stp_inj;

    int pass_cnt;
    int chk_cnt;
    int cyc;
    int start_cyc;
    int valid_cyc;
    int n_deser, n_valid, n_strt, n_par, n_stp, n_bad_edge;
    logic [7:0] rx_byte;
    logic [7:0] byte_last;
    logic [7:0] byte_prev;

    uart_rx_ctrl #(.PRESC_W(PW), .DATA_BITS(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .Prescale     (Prescale),
        .par_err      (par_err),
        .strt_glitch  (strt_glitch),
        .stp_err      (stp_err),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .dat_samp_en  (dat_samp_en),
        .strt_chk_en  (strt_chk_en),
        .deser_en     (deser_en),
        .par_chk_en   (par_chk_en),
        .stp_chk_en   (stp_chk_en),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    // Checker responders only answer while their strobe is up.
    assign par_err     = par_inj & par_chk_en;
    assign strt_glitch = glitch_inj & strt_chk_en;
    assign stp_err     = stp_inj & stp_chk_en;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: counts strobes and rebuilds the byte from the line at deser_en.
    always @(negedge CLK) begin
        if (RST) begin
            if (deser_en) begin
                n_deser = n_deser + 1;
                rx_byte = {RX_IN, rx_byte[7:1]};
                if (edge_cnt !== PW'((Prescale >> 1) + PW'(2))) n_bad_edge = n_bad_edge + 1;
            end
            if (data_valid) begin
                n_valid   = n_valid + 1;
                valid_cyc = cyc;
                byte_prev = byte_last;
                byte_last = rx_byte;
            end
            if (strt_chk_en) n_strt = n_strt + 1;
            if (par_chk_en)  n_par  = n_par + 1;
            if (stp_chk_en)  n_stp  = n_stp + 1;
        end
    end

    task automatic align();
        @(posedge CLK);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Assumes caller is aligned just after a rising edge.
    task automatic send_frame(input int p, input logic pe, input logic [7:0] data,
                              input logic pbit, input int stop_n);
        Prescale  = PW'(p);
        PAR_EN    = pe;
        start_cyc = cyc;
        hold(1'b0, p);
        for (int i = 0; i < 8; i++) hold(data[i], p);
        if (pe) hold(pbit, p);
        hold(1'b1, stop_n);
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = PW'(8);
        par_inj = 1'b0; glitch_inj = 1'b0; stp_inj = 1'b0;
        repeat (3) @(negedge CLK);
        chk_cnt++;
        if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
             data_valid, parity_error, frame_error} !== 18'd0)
            $display("FAIL reset_outputs: got e=%0d b=%0d samp=%b dv=%b pe=%b fe=%b expected all 0",
                     edge_cnt, bit_cnt, dat_samp_en, data_valid, parity_error, frame_error);
        else pass_cnt++;
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        chk_cnt++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0)
            $display("FAIL reset_idle: got samp=%b edge=%0d expected 0 0", dat_samp_en, edge_cnt);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int bd, bv, bs, bp, bb;
        align();
        bd = n_deser; bv = n_valid; bs = n_stp; bp = n_strt; bb = n_bad_edge;
        send_frame(8, 1'b0, 8'h55, 1'b0, 8);
        hold(1'b1, 4);
        chk_cnt++;
        if (n_deser - bd !== 8) $display("FAIL basic_deser_cnt: got %0d expected 8", n_deser - bd);
        else pass_cnt++;
        chk_cnt++;
        if (n_bad_edge - bb !== 0) $display("FAIL basic_deser_edge: got %0d off-edge pulses expected 0", n_bad_edge - bb);
        else pass_cnt++;
        chk_cnt++;
        if (rx_byte !== 8'h55) $display("FAIL basic_byte: got %h expected 55", rx_byte);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid - bv !== 1) $display("FAIL basic_valid_cnt: got %0d expected 1", n_valid - bv);
        else pass_cnt++;
        chk_cnt++;
        if (valid_cyc - start_cyc !== 80) $display("FAIL basic_latency: got %0d expected 80", valid_cyc - start_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (n_strt - bp !== 1 || n_stp - bs !== 1)
            $display("FAIL basic_chk_strobes: got strt=%0d stp=%0d expected 1 1", n_strt - bp, n_stp - bs);
        else pass_cnt++;
        chk_cnt++;
        if (parity_error !== 1'b0 || frame_error !== 1'b0)
            $display("FAIL basic_errors: got pe=%b fe=%b expected 0 0", parity_error, frame_error);
        else pass_cnt++;
        chk_cnt++;
        if (dat_samp_en !== 1'b0) $display("FAIL basic_back_idle: got samp=%b expected 0", dat_samp_en);
        else pass_cnt++;
    endtask

    task automatic test_start_glitch();
        int bd, bv, bs;
        bit got;
        align();
        bd = n_deser; bv = n_valid; bs = n_strt;
        Prescale = PW'(16); PAR_EN = 1'b0; glitch_inj = 1'b1;
        hold(1'b0, 2);
        RX_IN = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (strt_chk_en) got = 1'b1;
        end
        chk_cnt++;
        if (got !== 1'b1 || edge_cnt !== 6'd10)
            $display("FAIL glitch_chk_edge: got seen=%b edge=%0d expected 1 10", got, edge_cnt);
        else pass_cnt++;
        @(negedge CLK);
        chk_cnt++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0)
            $display("FAIL glitch_to_idle: got samp=%b edge=%0d expected 0 0", dat_samp_en, edge_cnt);
        else pass_cnt++;
        glitch_inj = 1'b0;
        repeat (40) @(negedge CLK);
        chk_cnt++;
        if (n_deser - bd !== 0 || n_valid - bv !== 0)
            $display("FAIL glitch_no_data: got deser=%0d valid=%0d expected 0 0", n_deser - bd, n_valid - bv);
        else pass_cnt++;
        chk_cnt++;
        if (n_strt - bs !== 1) $display("FAIL glitch_strt_cnt: got %0d expected 1", n_strt - bs);
        else pass_cnt++;
    endtask

    task automatic test_parity_err();
        int bv, bp;
        align();
        bv = n_valid; bp = n_par;
        par_inj = 1'b1;
        send_frame(8, 1'b1, 8'hA3, 1'b0, 8);
        hold(1'b1, 4);
        par_inj = 1'b0;
        chk_cnt++;
        if (n_par - bp !== 1) $display("FAIL par_chk_cnt: got %0d expected 1", n_par - bp);
        else pass_cnt++;
        chk_cnt++;
        if (parity_error !== 1'b1) $display("FAIL par_flag: got %b expected 1", parity_error);
        else pass_cnt++;
        chk_cnt++;
        if (frame_error !== 1'b0) $display("FAIL par_frame_flag: got %b expected 0", frame_error);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid - bv !== 0) $display("FAIL par_no_valid: got %0d expected 0", n_valid - bv);
        else pass_cnt++;
        chk_cnt++;
        if (rx_byte !== 8'hA3) $display("FAIL par_byte: got %h expected a3", rx_byte);
        else pass_cnt++;
    endtask

    task automatic test_stop_err();
        int bv, bp;
        align();
        bv = n_valid; bp = n_par;
        stp_inj = 1'b1;
        send_frame(8, 1'b0, 8'h3C, 1'b0, 8);
        hold(1'b1, 4);
        stp_inj = 1'b0;
        chk_cnt++;
        if (frame_error !== 1'b1) $display("FAIL stop_flag: got %b expected 1", frame_error);
        else pass_cnt++;
        chk_cnt++;
        if (parity_error !== 1'b0) $display("FAIL stop_par_cleared: got %b expected 0", parity_error);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid - bv !== 0 || n_par - bp !== 0)
            $display("FAIL stop_no_valid: got valid=%0d par=%0d expected 0 0", n_valid - bv, n_par - bp);
        else pass_cnt++;
        send_frame(8, 1'b0, 8'h81, 1'b0, 8);
        hold(1'b1, 4);
        chk_cnt++;
        if (frame_error !== 1'b0) $display("FAIL stop_flag_cleared: got %b expected 0", frame_error);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid - bv !== 1 || byte_last !== 8'h81)
            $display("FAIL stop_next_frame: got valid=%0d byte=%h expected 1 81", n_valid - bv, byte_last);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bd, bv;
        align();
        bd = n_deser; bv = n_valid;
        send_frame(8, 1'b0, 8'h0F, 1'b0, 8 / 2 + 4);
        send_frame(8, 1'b0, 8'hF0, 1'b0, 8);
        hold(1'b1, 4);
        chk_cnt++;
        if (n_valid - bv !== 2) $display("FAIL b2b_valid_cnt: got %0d expected 2", n_valid - bv);
        else pass_cnt++;
        chk_cnt++;
        if (n_deser - bd !== 16) $display("FAIL b2b_deser_cnt: got %0d expected 16", n_deser - bd);
        else pass_cnt++;
        chk_cnt++;
        if (byte_prev !== 8'h0F || byte_last !== 8'hF0)
            $display("FAIL b2b_bytes: got %h %h expected 0f f0", byte_prev, byte_last);
        else pass_cnt++;
        chk_cnt++;
        if (valid_cyc - start_cyc !== 80) $display("FAIL b2b_latency: got %0d expected 80", valid_cyc - start_cyc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int bv;
        bit got;
        align();
        bv = n_valid;
        Prescale = PW'(8); PAR_EN = 1'b0;
        hold(1'b0, 8);
        RX_IN = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (dat_samp_en && bit_cnt == 4'd4) got = 1'b1;
        end
        chk_cnt++;
        if (got !== 1'b1) $display("FAIL rst_reach_bit4: got %b expected 1", got);
        else pass_cnt++;
        RST = 1'b0;
        #1;
        chk_cnt++;
        if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
             data_valid, parity_error, frame_error} !== 18'd0)
            $display("FAIL rst_async_clear: got e=%0d b=%0d samp=%b expected all 0",
                     edge_cnt, bit_cnt, dat_samp_en);
        else pass_cnt++;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(negedge CLK);
        chk_cnt++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || n_valid - bv !== 0)
            $display("FAIL rst_stays_idle: got samp=%b edge=%0d valid=%0d expected 0 0 0",
                     dat_samp_en, edge_cnt, n_valid - bv);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; chk_cnt = 0; cyc = 0; start_cyc = 0; valid_cyc = 0;
        n_deser = 0; n_valid = 0; n_strt = 0; n_par = 0; n_stp = 0; n_bad_edge = 0;
        rx_byte = 8'h00; byte_last = 8'h00; byte_prev = 8'h00;
        test_reset();
        test_basic();
        test_start_glitch();
        test_parity_err();
        test_stop_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
